uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Transmit sequencer for the UART. Pops 10-bit words from the show-ahead TX FIFO and frames them
//  onto txd as start/data/parity/stop bits, with optional inter-frame gap and CTS flow control.
//  Frame format comes from the APB config registers (r_*) and is shadowed, so it changes only between frames.
// PARAMETERS
//  CTS_SYNC  2  flop stages on cts_n before use (>=2)
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   async active-low reset
//  r_clkdiv        in   12  tick divider: 1 tick = r_clkdiv+1 clk
//  r_oversampling  in   4   ticks per bit minus 1
//  r_interval_bit  in   4   idle bit-times inserted after stop (0 = none)
//  r_stop_bit      in   1   0 = 1 stop bit, 1 = 2 stop bits
//  r_parity_en     in   1   1 = parity bit present
//  r_parity        in   2   0 even, 1 odd, 2 mark(1), 3 space(0)
//  r_data_bit      in   2   data bits = 7 + r_data_bit (7..10)
//  r_cts           in   1   1 = CTS flow control enabled
//  r_update        in   1   level: load shadow config while IDLE
//  r_tx_logic_clr  in   1   level: synchronous abort/hold in IDLE
//  cts_n           in   1   CTS pin, async, active-low
//  fifo_empty      in   1   TX FIFO empty
//  fifo_rdata      in   10  TX FIFO head word, valid when !fifo_empty
//  fifo_pop        out  1   one-cycle pop strobe
//  txd             out  1   serial output, idle high
//  tx_busy         out  1   state != IDLE
//  tx_done         out  1   one-cycle pulse at end of last stop bit
// BEHAVIOUR
//  Reset: txd=1, fifo_pop=0, tx_busy=0, tx_done=0. FSM=IDLE; all counters 0.
//  Shadows reset to clkdiv=0x016, os=0xF, interval=0, stop=0, par_en=0, par=0, data_bit=1.
//  Bit time BT = (clkdiv+1)*(os+1) clk, from shadow. Default BT = 23*16 = 368 clk.
//  Min BT = 1 clk (both fields 0); this case must work.
//  Baud counter restarts at START entry, so every bit is exactly BT clk long.
//  Shadows load from r_* in any IDLE cycle with r_update=1. While busy they are frozen.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> [GAP] -> IDLE.
//  IDLE launch: !fifo_empty & !r_tx_logic_clr & (!r_cts | cts_sync==0).
//   - On launch: fifo_pop=1 for that cycle and fifo_rdata is latched into the shift register.
//   - If r_update=1 in the same cycle, the new shadow values apply to this frame.
//  Timing: pop in cycle N -> START in N+1. txd is registered, so txd=0 is seen from N+1.
//  START: txd=0 for 1 BT. DATA: shifts LSB first for (7+data_bit) BTs.
//  PARITY (only if par_en), 1 BT:
//   - even/odd = XOR of the active data bits only (XOR, or its complement for odd).
//   - mark drives 1, space drives 0.
//  STOP: txd=1 for 1 or 2 BT. tx_done pulses in the final cycle of STOP.
//  GAP: txd=1 for interval*BT. Skipped when interval=0.
//  The FSM always spends >=1 cycle in IDLE between frames.
//   - Back-to-back spacing, falling start edge to falling start edge = (frame bits + interval)*BT + 1 clk.
//  CTS is sampled only at launch. Deassertion mid-frame does not stop the current frame.
//  r_tx_logic_clr=1 in any state: next cycle FSM=IDLE, txd=1, counters=0, no tx_done, no pop.
//   - The aborted word is lost. While clr is held, no launch occurs.
//  Bits above the active data width in fifo_rdata are ignored.
//  tx_busy=1 from the START cycle through the last GAP/STOP cycle.
// TESTING
//  Default cfg, push 0x0A5 -> txd: 0,1,0,1,0,0,1,0,1,1 at 368 clk/bit; tx_done at 3680 clk; one pop.
//  clkdiv=0, os=0, data_bit=0, par_en=1, par=1, stop=1, push 0x055 -> 1 clk/bit: 0,1010101,1,1,1 (odd parity=1).
//  r_cts=1, cts_n=1, push 2 words -> no pop, txd=1.
//   - Drop cts_n -> pop 2+CTS_SYNC cycles later; raising cts_n mid-frame still completes the frame.
//  interval=2, BT=4, 8N1, push 3 words -> 3 pops; start-edge spacing 49 clk; txd=1 through each gap.
//  r_tx_logic_clr pulse during DATA bit 3 -> txd=1 next cycle, tx_busy=0, no tx_done.
//   - Next FIFO word then starts cleanly.
//  Change r_data_bit with r_update=1 mid-frame -> current frame keeps old width; next frame uses new width.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the UART transmit sequencer and its show-ahead TX FIFO,
// plus the serial line and status strobes produced by the sequencer.
interface uart_tx_ctrl_if;
    logic       fifo_empty;
    logic [9:0] fifo_rdata;
    logic       fifo_pop;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_pop,
        output txd,
        output tx_busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_pop,
        input  txd,
        input  tx_busy,
        input  tx_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops words from a show-ahead FIFO and frames them onto txd as
// start/data/parity/stop bits with an optional idle gap, honouring CTS at launch time.
module uart_tx_ctrl #(
    parameter int CTS_SYNC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] r_clkdiv,
    input  logic [3:0]  r_oversampling,
    input  logic [3:0]  r_interval_bit,
    input  logic        r_stop_bit,
    input  logic        r_parity_en,
    input  logic [1:0]  r_parity,
    input  logic [1:0]  r_data_bit,
    input  logic        r_cts,
    input  logic        r_update,
    input  logic        r_tx_logic_clr,
    input  logic        cts_n,
    uart_tx_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CTS_SYNC-1:0] cts_sync_r;
    logic [11:0]         clkdiv_r;
    logic [3:0]          os_r;
    logic [3:0]          interval_r;
    logic                stop_r;
    logic                par_en_r;
    logic [1:0]          par_r;
    logic [1:0]          data_bit_r;
    logic [11:0]         div_cnt_r;
    logic [3:0]          os_cnt_r;
    logic [3:0]          bit_cnt_r;
    logic [3:0]          bit_cnt_s;
    logic [9:0]          data_r;
    logic                txd_r;
    logic                txd_s;
    logic                launch_s;
    logic                bit_end_s;
    logic                last_data_s;
    logic                last_stop_s;
    logic                last_gap_s;
    logic                cts_ok_s;

    // Parity over the active data bits only; mark/space ignore the data entirely.
    function automatic logic parity_calc(input logic [9:0] data,
                                         input logic [1:0] data_bit,
                                         input logic [1:0] par);
        logic [9:0] mask;
        logic       x;
        case (data_bit)
            2'd0:    mask = 10'h07F;
            2'd1:    mask = 10'h0FF;
            2'd2:    mask = 10'h1FF;
            default: mask = 10'h3FF;
        endcase
        x = ^(data & mask);
        case (par)
            2'd0:    parity_calc = x;
            2'd1:    parity_calc = ~x;
            2'd2:    parity_calc = 1'b1;
            default: parity_calc = 1'b0;
        endcase
    endfunction

    assign cts_ok_s    = ~r_cts | ~cts_sync_r[CTS_SYNC-1];
    assign launch_s    = (state_r == ST_IDLE) & ~bus.fifo_empty & ~r_tx_logic_clr & cts_ok_s;
    assign bit_end_s   = (div_cnt_r == clkdiv_r) & (os_cnt_r == os_r);
    assign last_data_s = (bit_cnt_r == ({2'b00, data_bit_r} + 4'd6));
    assign last_stop_s = (bit_cnt_r == {3'b000, stop_r});
    assign last_gap_s  = (bit_cnt_r == (interval_r - 4'd1));

    assign bus.fifo_pop = launch_s;
    assign bus.txd      = txd_r;
    assign bus.tx_busy  = (state_r != ST_IDLE);
    assign bus.tx_done  = (state_r == ST_STOP) & bit_end_s & last_stop_s & ~r_tx_logic_clr;

    // CTS pin synchroniser; resets to the deasserted (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_sync_r <= {CTS_SYNC{1'b1}};
        end else begin
            cts_sync_r <= {cts_sync_r[CTS_SYNC-2:0], cts_n};
        end
    end

    // Shadow frame configuration, only refreshed while the sequencer is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_r   <= 12'h016;
            os_r       <= 4'hF;
            interval_r <= 4'd0;
            stop_r     <= 1'b0;
            par_en_r   <= 1'b0;
            par_r      <= 2'd0;
            data_bit_r <= 2'd1;
        end else if ((state_r == ST_IDLE) && r_update) begin
            clkdiv_r   <= r_clkdiv;
            os_r       <= r_oversampling;
            interval_r <= r_interval_bit;
            stop_r     <= r_stop_bit;
            par_en_r   <= r_parity_en;
            par_r      <= r_parity;
            data_bit_r <= r_data_bit;
        end else begin
            clkdiv_r   <= clkdiv_r;
            os_r       <= os_r;
            interval_r <= interval_r;
            stop_r     <= stop_r;
            par_en_r   <= par_en_r;
            par_r      <= par_r;
            data_bit_r <= data_bit_r;
        end
    end

    // Baud counters: held at zero in IDLE so each frame's first bit is a full bit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= 12'd0;
            os_cnt_r  <= 4'd0;
        end else if (r_tx_logic_clr || (state_r == ST_IDLE) || bit_end_s) begin
            div_cnt_r <= 12'd0;
            os_cnt_r  <= 4'd0;
        end else if (div_cnt_r == clkdiv_r) begin
            div_cnt_r <= 12'd0;
            os_cnt_r  <= os_cnt_r + 4'd1;
        end else begin
            div_cnt_r <= div_cnt_r + 12'd1;
            os_cnt_r  <= os_cnt_r;
        end
    end

    // Word being transmitted, captured from the FIFO head on the pop cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 10'd0;
        end else if (launch_s) begin
            data_r <= bus.fifo_rdata;
        end else begin
            data_r <= data_r;
        end
    end

    // FSM state, bit counter and registered serial output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            txd_r     <= txd_s;
        end
    end

    // Next-state logic; txd_s is the level of the bit that starts in the next cycle.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        txd_s     = txd_r;
        if (r_tx_logic_clr) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 4'd0;
            txd_s     = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_s = 4'd0;
                    if (launch_s) begin
                        state_s = ST_START;
                        txd_s   = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                        txd_s   = 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_s   = ST_DATA;
                        bit_cnt_s = 4'd0;
                        txd_s     = data_r[0];
                    end else begin
                        state_s   = ST_START;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s && last_data_s) begin
                        bit_cnt_s = 4'd0;
                        if (par_en_r) begin
                            state_s = ST_PARITY;
                            txd_s   = parity_calc(data_r, data_bit_r, par_r);
                        end else begin
                            state_s = ST_STOP;
                            txd_s   = 1'b1;
                        end
                    end else if (bit_end_s) begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                        txd_s     = data_r[bit_cnt_r + 4'd1];
                    end else begin
                        state_s   = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_s   = ST_STOP;
                        bit_cnt_s = 4'd0;
                        txd_s     = 1'b1;
                    end else begin
                        state_s   = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    txd_s = 1'b1;
                    if (bit_end_s && last_stop_s) begin
                        bit_cnt_s = 4'd0;
                        if (interval_r != 4'd0) begin
                            state_s = ST_GAP;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else if (bit_end_s) begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else begin
                        state_s   = ST_STOP;
                    end
                end
                ST_GAP: begin
                    txd_s = 1'b1;
                    if (bit_end_s && last_gap_s) begin
                        state_s   = ST_IDLE;
                        bit_cnt_s = 4'd0;
                    end else if (bit_end_s) begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else begin
                        state_s   = ST_GAP;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    bit_cnt_s = 4'd0;
                    txd_s     = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a FIFO model feeds words, expected frames are queued
// at push time and compared bit by bit by a line monitor.
module tb_uart_tx_ctrl;
    localparam int CTS_SYNC = 2;

    typedef struct {
        int clkdiv; int os; int interval; int stop; int par_en; int par; int db;
    } cfg_t;

    typedef struct {
        logic [31:0] bits; int nbits; int gap; int bt;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] r_clkdiv;
    logic [3:0]  r_oversampling;
    logic [3:0]  r_interval_bit;
    logic        r_stop_bit;
    logic        r_parity_en;
    logic [1:0]  r_parity;
    logic [1:0]  r_data_bit;
    logic        r_cts;
    logic        r_update;
    logic        r_tx_logic_clr;
    logic        cts_n;

    uart_tx_ctrl_if bus();

    uart_tx_ctrl #(.CTS_SYNC(CTS_SYNC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r_clkdiv       (r_clkdiv),
        .r_oversampling (r_oversampling),
        .r_interval_bit (r_interval_bit),
        .r_stop_bit     (r_stop_bit),
        .r_parity_en    (r_parity_en),
        .r_parity       (r_parity),
        .r_data_bit     (r_data_bit),
        .r_cts          (r_cts),
        .r_update       (r_update),
        .r_tx_logic_clr (r_tx_logic_clr),
        .cts_n          (cts_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] fifo_q[$];
    frame_t     sb[$];
    int         starts[$];
    int         cyc = 0;
    int         pops = 0;
    int         dones = 0;
    bit         mon_en = 1'b1;
    bit         mon_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic frame_t build(input logic [9:0] w, input cfg_t c);
        frame_t f;
        int     k;
        logic   p;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < 7 + c.db; i++) begin
            f.bits[k] = w[i];
            p = p ^ w[i];
            k++;
        end
        if (c.par_en != 0) begin
            case (c.par)
                0:       f.bits[k] = p;
                1:       f.bits[k] = ~p;
                2:       f.bits[k] = 1'b1;
                default: f.bits[k] = 1'b0;
            endcase
            k++;
        end
        k = k + 1 + c.stop;
        f.nbits = k;
        f.gap   = c.interval;
        f.bt    = (c.clkdiv + 1) * (c.os + 1);
        return f;
    endfunction

    task automatic apply_cfg(input cfg_t c);
        r_clkdiv       = 12'(c.clkdiv);
        r_oversampling = 4'(c.os);
        r_interval_bit = 4'(c.interval);
        r_stop_bit     = 1'(c.stop);
        r_parity_en    = 1'(c.par_en);
        r_parity       = 2'(c.par);
        r_data_bit     = 2'(c.db);
    endtask

    task automatic push(input logic [9:0] w, input cfg_t c, input bit expect_frame);
        @(negedge clk);
        fifo_q.push_back(w);
        if (expect_frame) sb.push_back(build(w, c));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((sb.size() != 0 || mon_busy || bus.tx_busy || fifo_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_pop(input int p0, input string tag);
        int n = 0;
        while (pops == p0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(pops - p0), 32'd1);
    endtask

    // Show-ahead FIFO model: pops the head one step after the pop strobe is seen.
    initial begin : fifo_model
        bit p;
        bit d;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 10'h000;
        forever begin
            @(posedge clk);
            cyc++;
            p = bus.fifo_pop;
            d = bus.tx_done;
            #1;
            if (p) begin
                pops++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            if (d) dones++;
            bus.fifo_empty = (fifo_q.size() == 0);
            bus.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 10'h000;
        end
    end

    // Line monitor: on a falling start edge, checks each bit at the last cycle of its bit time.
    initial begin : line_monitor
        logic   prev;
        frame_t f;
        int     off;
        int     tgt;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !bus.txd) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                check_eq("frame_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    f   = sb.pop_front();
                    off = 0;
                    for (int i = 0; i < f.nbits + f.gap; i++) begin
                        tgt = (i + 1) * f.bt - 1;
                        repeat (tgt - off) @(negedge clk);
                        off = tgt;
                        check_eq($sformatf("%s%0d", (i < f.nbits) ? "bit" : "gap", i),
                                 32'(bus.txd), 32'(f.bits[i]));
                        check_eq($sformatf("tx_done@%0d", i), 32'(bus.tx_done), 32'(i == f.nbits - 1));
                        check_eq($sformatf("tx_busy@%0d", i), 32'(bus.tx_busy), 32'd1);
                    end
                end
                mon_busy = 1'b0;
            end
            prev = bus.txd;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        cfg_t       dflt;
        cfg_t       c;
        cfg_t       c2;
        cfg_t       vt[5];
        logic [9:0] vw[5];
        int         p0;
        int         d0;
        int         k;

        dflt  = '{22, 15, 0, 0, 0, 0, 1};
        vt[0] = '{0, 0, 0, 1, 1, 1, 0};
        vt[1] = '{0, 0, 0, 0, 1, 0, 2};
        vt[2] = '{1, 0, 0, 0, 1, 2, 3};
        vt[3] = '{0, 1, 0, 1, 1, 3, 3};
        vt[4] = '{2, 1, 0, 0, 1, 0, 0};
        vw[0] = 10'h055; vw[1] = 10'h1C3; vw[2] = 10'h2F0; vw[3] = 10'h30F; vw[4] = 10'h3AA;

        apply_cfg('{5, 0, 3, 1, 1, 1, 0});
        r_cts = 1'b0; r_update = 1'b0; r_tx_logic_clr = 1'b0; cts_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_txd",     32'(bus.txd),      32'd1);
        check_eq("rst_pop",     32'(bus.fifo_pop), 32'd0);
        check_eq("rst_busy",    32'(bus.tx_busy),  32'd0);
        check_eq("rst_done",    32'(bus.tx_done),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Shadow defaults: r_* differ but r_update=0, so the frame is 8N1 at 368 clk/bit.
        p0 = pops; d0 = dones;
        push(10'h0A5, dflt, 1'b1);
        wait_idle(6000, "t1_complete");
        check_eq("t1_pops",  32'(pops - p0),  32'd1);
        check_eq("t1_dones", 32'(dones - d0), 32'd1);

        r_update = 1'b1;
        for (int v = 0; v < 5; v++) begin
            apply_cfg(vt[v]);
            p0 = pops;
            push(vw[v], vt[v], 1'b1);
            wait_idle(500, $sformatf("t2_complete%0d", v));
            check_eq($sformatf("t2_pops%0d", v), 32'(pops - p0), 32'd1);
        end

        // CTS flow control
        c = '{1, 1, 0, 0, 0, 0, 1};
        apply_cfg(c);
        r_cts = 1'b1;
        cts_n = 1'b1;
        repeat (CTS_SYNC + 2) @(negedge clk);
        p0 = pops; d0 = dones;
        push(10'h0C3, c, 1'b1);
        push(10'h13C, c, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("cts_hold_pops", 32'(pops - p0),   32'd0);
        check_eq("cts_hold_txd",  32'(bus.txd),     32'd1);
        check_eq("cts_hold_busy", 32'(bus.tx_busy), 32'd0);
        cts_n = 1'b0;
        k = 0;
        while (!bus.fifo_pop && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("cts_latency", 32'(k >= CTS_SYNC && k <= CTS_SYNC + 2), 32'd1);
        repeat (10) @(negedge clk);
        cts_n = 1'b1;
        k = 0;
        while (dones == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("cts_frame1_done", 32'(dones - d0), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("cts_block_pops", 32'(pops - p0), 32'd1);
        check_eq("cts_block_txd",  32'(bus.txd),   32'd1);
        check_eq("cts_block_sb",   32'(sb.size()), 32'd1);
        cts_n = 1'b0;
        wait_idle(300, "cts_complete");
        check_eq("cts_pops", 32'(pops - p0), 32'd2);
        r_cts = 1'b0;

        // Inter-frame gap: 8N1, BT=4, two idle bit-times after stop.
        c = '{0, 3, 2, 0, 0, 0, 1};
        apply_cfg(c);
        @(negedge clk);
        starts.delete();
        p0 = pops;
        push(10'h0F0, c, 1'b1);
        push(10'h00F, c, 1'b1);
        push(10'h081, c, 1'b1);
        wait_idle(500, "gap_complete");
        check_eq("gap_pops",   32'(pops - p0),     32'd3);
        check_eq("gap_starts", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            check_eq("gap_space01", 32'(starts[1] - starts[0]), 32'd49);
            check_eq("gap_space12", 32'(starts[2] - starts[1]), 32'd49);
        end

        // Abort during data bit 3 (BT=4, 8N1).
        c = '{0, 3, 0, 0, 0, 0, 1};
        apply_cfg(c);
        @(negedge clk);
        mon_en = 1'b0;
        p0 = pops; d0 = dones;
        push(10'h0F3, c, 1'b0);
        wait_pop(p0, "abort_pop");
        repeat (17) @(negedge clk);
        check_eq("abort_pre_bit3", 32'(bus.txd), 32'd0);
        r_tx_logic_clr = 1'b1;
        @(negedge clk);
        check_eq("abort_txd",  32'(bus.txd),     32'd1);
        check_eq("abort_busy", 32'(bus.tx_busy), 32'd0);
        check_eq("abort_done", 32'(bus.tx_done), 32'd0);
        r_tx_logic_clr = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("abort_no_done", 32'(dones - d0), 32'd0);
        check_eq("abort_idle_txd", 32'(bus.txd),   32'd1);
        mon_en = 1'b1;
        push(10'h05A, c, 1'b1);
        wait_idle(300, "abort_next_complete");
        check_eq("abort_next_done", 32'(dones - d0), 32'd1);

        // Held clear blocks launch; the word goes out after release.
        p0 = pops;
        r_tx_logic_clr = 1'b1;
        push(10'h1E1, c, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("clr_hold_pops", 32'(pops - p0),   32'd0);
        check_eq("clr_hold_busy", 32'(bus.tx_busy), 32'd0);
        r_tx_logic_clr = 1'b0;
        wait_idle(300, "clr_release_complete");
        check_eq("clr_release_pops", 32'(pops - p0), 32'd1);

        // Width change while busy applies to the next frame only.
        c  = '{1, 0, 0, 0, 0, 0, 1};
        c2 = '{1, 0, 0, 0, 0, 0, 3};
        apply_cfg(c);
        @(negedge clk);
        p0 = pops;
        push(10'h2C5, c, 1'b1);
        push(10'h3A7, c2, 1'b1);
        wait_pop(p0, "width_pop1");
        r_data_bit = 2'd3;
        wait_idle(300, "width_complete");
        check_eq("width_pops", 32'(pops - p0), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
